// File: rtl/gf8_reduce_seq_pkg.sv
// Shared GF(2^8) definitions for the sequential reducer: field constants,
// element/product types and the reducer FSM state encoding.
package gf8_reduce_seq_pkg;

    localparam logic [8:0] GF8_POLY = 9'h11B;
    localparam int unsigned GF8_W = 8;

    typedef logic [14:0] gf8_prod_t;
    typedef logic [7:0]  gf8_t;
    typedef logic [3:0]  gf8_cnt_t;

    // Bit positions walked by the reducer, from the product MSB down to x^8.
    localparam gf8_cnt_t GF8_CNT_TOP  = 4'd14;
    localparam gf8_cnt_t GF8_CNT_LAST = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } gf8_state_t;

endpackage

// File: rtl/gf8_reduce_step.sv
// One reduction step: clears bit i_cnt of the partial remainder by XORing in
// the field polynomial aligned to that bit. Purely combinational.
module gf8_reduce_step
    import gf8_reduce_seq_pkg::*;
#(
    parameter logic [8:0] POLY = GF8_POLY
) (
    input  logic [14:0] i_r,
    input  logic [3:0]  i_cnt,
    output logic [14:0] o_r_next
);

    logic [15:0] w_r_ext;
    logic        w_lead;
    logic [3:0]  w_amt;
    logic [14:0] w_poly_sh;

    always_comb begin
        w_r_ext   = {1'b0, i_r};
        w_lead    = w_r_ext[i_cnt];
        w_amt     = i_cnt - GF8_CNT_LAST;
        w_poly_sh = 15'(POLY) << w_amt;
        o_r_next  = i_r;
        // Positions below x^8 are already reduced; leave them untouched.
        if ((i_cnt >= GF8_CNT_LAST) && w_lead) begin
            o_r_next = i_r ^ w_poly_sh;
        end
    end

endmodule

// File: rtl/gf8_reduce_seq.sv
// Sequential GF(2^8) reducer with optional accumulate: reduces a 15-bit
// carry-less product one bit per cycle, valid/ready on both sides.
module gf8_reduce_seq
    import gf8_reduce_seq_pkg::*;
#(
    parameter logic [8:0]  POLY = GF8_POLY,
    parameter int unsigned W    = GF8_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-2:0] in_prod,
    input  logic           in_acc,
    input  logic           acc_clr,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data
);

    gf8_state_t r_state;
    gf8_state_t w_state_next;

    gf8_prod_t  r_rem;
    gf8_prod_t  w_rem_next;
    gf8_cnt_t   r_cnt;
    logic       r_acc_sel;
    gf8_t       r_acc;
    gf8_t       r_out_data;
    gf8_t       w_result;

    logic       w_idle;
    logic       w_busy;
    logic       w_last;
    logic       w_accept;

    gf8_reduce_step #(
        .POLY (POLY)
    ) u_step (
        .i_r      (r_rem),
        .i_cnt    (r_cnt),
        .o_r_next (w_rem_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_next = ST_BUSY;
            ST_BUSY: if (w_last)    w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    // in_ready is gated by rst_n so it reads low for the whole reset window.
    always_comb begin
        w_idle    = (r_state == ST_IDLE);
        w_busy    = (r_state == ST_BUSY);
        out_valid = (r_state == ST_DONE);
        in_ready  = w_idle && rst_n;
        w_accept  = in_valid && in_ready;
        w_last    = w_busy && (r_cnt == GF8_CNT_LAST);
    end

    assign w_result = w_rem_next[7:0] ^ (r_acc_sel ? r_acc : '0);
    assign out_data = r_out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem      <= '0;
            r_cnt      <= '0;
            r_acc_sel  <= 1'b0;
            r_out_data <= '0;
        end else begin
            if (w_accept) begin
                r_rem     <= in_prod;
                r_acc_sel <= in_acc;
                r_cnt     <= GF8_CNT_TOP;
            end else if (w_busy) begin
                r_rem <= w_rem_next;
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_last) begin
                r_out_data <= w_result;
            end
        end
    end

    // A clear on the accept edge lands before the result is formed, so that
    // result sees a zero accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (acc_clr && !w_busy) begin
            r_acc <= '0;
        end else if (w_last && r_acc_sel) begin
            r_acc <= w_result;
        end
    end

endmodule

// File: tb/tb_gf8_reduce_seq.sv
// Self-checking bench for gf8_reduce_seq: directed vectors plus a scoreboard
// driven by a power-table GF(2^8) model.
module tb_gf8_reduce_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [14:0] in_prod = '0;
    logic        in_acc = 1'b0;
    logic        acc_clr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;

    gf8_reduce_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_acc    (in_acc),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] exp;
        int         acc_edge;
    } exp_t;
    exp_t sb[$];

    logic [7:0] acc_m = '0;
    logic [7:0] last_out = '0;
    int  a_edge = -100;
    int  hs_edge = -100;
    int  n_acc = 0;
    int  n_hs = 0;
    bit  prev_v = 1'b0;
    bit  stall_mode = 1'b0;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
    endfunction

    // Remainder as a sum of precomputed x^i mod P terms.
    function automatic logic [7:0] gf_mod(input logic [14:0] p);
        logic [7:0] pw = 8'h01;
        logic [7:0] res = 8'h00;
        for (int i = 0; i < 15; i++) begin
            if (p[i]) res ^= pw;
            pw = xtime(pw);
        end
        return res;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] res = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) res ^= aa;
            aa = xtime(aa);
        end
        return res;
    endfunction

    function automatic logic [14:0] clmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= (15'(a) << i);
        end
        return p;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard / compare process.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            acc_m  = '0;
            prev_v = 1'b0;
            n_acc  = 0;
            n_hs   = 0;
            a_edge = -100;
        end else begin
            if (out_valid) begin
                chk("valid_expected", int'(sb.size() > 0), 1);
                chk("ready_low_in_done", int'(in_ready), 0);
                if (sb.size() > 0) begin
                    chk("out_data", int'(out_data), int'(sb[0].exp));
                    if (!prev_v) chk("latency", cyc - sb[0].acc_edge, 7);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        n_hs++;
                        hs_edge  = cyc + 1;
                        last_out = out_data;
                    end
                end
            end
            prev_v = out_valid && !out_ready;
            if (acc_clr && !((cyc >= a_edge) && (cyc <= a_edge + 6))) acc_m = '0;
            if (in_valid && in_ready) begin
                exp_t e;
                e.exp      = gf_mod(in_prod) ^ (in_acc ? acc_m : 8'h00);
                e.acc_edge = cyc + 1;
                if (in_acc) acc_m = e.exp;
                sb.push_back(e);
                a_edge = cyc + 1;
                n_acc++;
            end
        end
    end

    always @(posedge clk) begin
        if (stall_mode) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [14:0] p, input bit acc, input bit clr);
        bit ok = 1'b0;
        in_prod  = p;
        in_acc   = acc;
        acc_clr  = clr;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_accepted", int'(ok), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_acc   = 1'b0;
        acc_clr  = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #2;
            if ((n_hs == n_acc) && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain", int'(ok), 1);
    endtask

    task automatic clr_pulse();
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int save;
        int n_before;
        bit seen;

        #2;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #3 chk("idle_in_ready", int'(in_ready), 1);

        chk("model_clmul", int'(clmul(8'h57, 8'h83)), 32'h2B79);
        chk("model_mod", int'(gf_mod(15'h2B79)), 32'hC1);
        chk("model_mod_x14", int'(gf_mod(15'h4000)), 32'h9A);
        chk("model_mul", int'(gf_mul(8'h57, 8'h83)), 32'hC1);

        @(posedge clk);
        #1;
        send(15'h2B79, 1'b0, 1'b0);
        wait_drain();
        chk("t1_2b79", int'(last_out), 32'hC1);

        send(15'h4000, 1'b0, 1'b0);
        wait_drain();
        chk("t2_x14", int'(last_out), 32'h9A);
        send(15'h00FF, 1'b0, 1'b0);
        wait_drain();
        chk("t2_pass", int'(last_out), 32'hFF);

        clr_pulse();
        send(15'h2B79, 1'b1, 1'b0);
        save = a_edge;
        send(15'h4000, 1'b1, 1'b0);
        chk("throughput", a_edge - save, 9);
        wait_drain();
        chk("t3_acc", int'(last_out), 32'h5B);
        send(15'h4000, 1'b1, 1'b1);
        wait_drain();
        chk("t3_clr_first", int'(last_out), 32'h9A);

        send(15'h00FF, 1'b1, 1'b0);
        clr_pulse();
        wait_drain();
        chk("busy_clr_res", int'(last_out), 32'h65);
        send(15'h0000, 1'b1, 1'b0);
        wait_drain();
        chk("busy_clr_kept", int'(last_out), 32'h65);

        out_ready = 1'b0;
        send(15'h2B79, 1'b0, 1'b0);
        n_before = n_acc;
        fork
            send(15'h00FF, 1'b0, 1'b0);
        join_none
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #2;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t4_valid_seen", int'(seen), 1);
        repeat (5) begin
            @(posedge clk);
            #2;
            chk("t4_stall_ready", int'(in_ready), 0);
            chk("t4_not_taken", n_acc, n_before);
            chk("t4_hold", int'(out_data), 32'hC1);
        end
        out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #2;
            if (!in_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t4_pending_taken", int'(seen), 1);
        chk("t4_accept_after_hs", a_edge - hs_edge, 1);
        wait_drain();
        chk("t4_second", int'(last_out), 32'hFF);

        send(15'h2B79, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_valid", int'(out_valid), 0);
        chk("t5_data", int'(out_data), 0);
        chk("t5_ready", int'(in_ready), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(15'h4000, 1'b1, 1'b0);
        wait_drain();
        chk("t5_after", int'(last_out), 32'h9A);

        stall_mode = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            send(clmul(a, b), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end
        wait_drain();
        stall_mode = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
